// File: rtl/ascon_job_sched_pkg.sv
// Shared types and constants for the ASCON job scheduler.
// The ASCON_SCHED_STATS_EN build uses the saturating counter helpers below.
package ascon_job_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        BUSY    = 3'd2,
        TAG     = 3'd3,
        RELEASE = 3'd4
    } sched_state_e;

    localparam int STAT_CNT_WIDTH = 16;
    localparam int BUSY_CNT_WIDTH = 32;

    function automatic logic [STAT_CNT_WIDTH-1:0] sat_inc_stat(
        input logic [STAT_CNT_WIDTH-1:0] val
    );
        logic [STAT_CNT_WIDTH-1:0] res;
        if (val == {STAT_CNT_WIDTH{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(STAT_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    function automatic logic [BUSY_CNT_WIDTH-1:0] sat_inc_busy(
        input logic [BUSY_CNT_WIDTH-1:0] val
    );
        logic [BUSY_CNT_WIDTH-1:0] res;
        if (val == {BUSY_CNT_WIDTH{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(BUSY_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/ascon_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping past NUM_REQ-1 back to 0.
module ascon_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan requesters in priority order starting at the pointer
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!valid_o && req_i[w_cand]) begin
                valid_o       = 1'b1;
                idx_o         = w_cand;
                gnt_o[w_cand] = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/ascon_job_sched.sv
// Round-robin scheduler sharing one ASCON core among NUM_REQ requesters.
// Optional macro ASCON_SCHED_STATS_EN adds per-requester job and busy-cycle counters.
module ascon_job_sched
    import ascon_job_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int BLOCK_AW    = 7,
    parameter int DELAY_WIDTH = 16,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*BLOCK_AW-1:0]     ad_blk_no_i,
    input  logic [NUM_REQ*(BLOCK_AW+1)-1:0] pt_blk_no_i,
    input  logic [NUM_REQ*DELAY_WIDTH-1:0]  delay_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [IDX_W-1:0]                grant_idx_o,
    output logic                            busy_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic                            core_start_o,
    input  logic                            core_ready_i,
    input  logic                            core_tag_valid_i,
    output logic [BLOCK_AW-1:0]             core_ad_blk_no_o,
    output logic [BLOCK_AW:0]               core_pt_blk_no_o,
    output logic [DELAY_WIDTH-1:0]          core_delay_o
`ifdef ASCON_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_CNT_WIDTH-1:0] job_cnt_o,
    output logic [BUSY_CNT_WIDTH-1:0]         busy_cycles_o
`endif
);

    sched_state_e            r_state;
    sched_state_e            w_state_nxt;
    logic [NUM_REQ-1:0]      r_grant;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_ptr;
    logic [BLOCK_AW-1:0]     r_ad;
    logic [BLOCK_AW:0]       r_pt;
    logic [DELAY_WIDTH-1:0]  r_dl;

    logic [NUM_REQ-1:0]      w_arb_gnt;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_valid;
    logic                    w_launch;
    logic                    w_release;

    logic [BLOCK_AW-1:0]     w_ad_arr [NUM_REQ];
    logic [BLOCK_AW:0]       w_pt_arr [NUM_REQ];
    logic [DELAY_WIDTH-1:0]  w_dl_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_ad_arr[g] = ad_blk_no_i[g*BLOCK_AW +: BLOCK_AW];
        assign w_pt_arr[g] = pt_blk_no_i[g*(BLOCK_AW+1) +: (BLOCK_AW+1)];
        assign w_dl_arr[g] = delay_i[g*DELAY_WIDTH +: DELAY_WIDTH];
    end

    ascon_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .gnt_o   (w_arb_gnt),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    // Arbitration only counts in IDLE with the core ready
    assign w_launch  = (r_state == IDLE) && core_ready_i && w_arb_valid;
    assign w_release = (r_state == RELEASE) && core_ready_i;

    // Next-state logic for the job lifecycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_state_nxt = LAUNCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LAUNCH: begin
                if (!core_ready_i) begin
                    w_state_nxt = BUSY;
                end else begin
                    w_state_nxt = LAUNCH;
                end
            end
            BUSY: begin
                if (core_tag_valid_i) begin
                    w_state_nxt = TAG;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            TAG: begin
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (core_ready_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RELEASE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, owner index and job configuration are captured only at launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_idx   <= '0;
            r_ad    <= '0;
            r_pt    <= '0;
            r_dl    <= '0;
        end else if (w_launch) begin
            r_grant <= w_arb_gnt;
            r_idx   <= w_arb_idx;
            r_ad    <= w_ad_arr[w_arb_idx];
            r_pt    <= w_pt_arr[w_arb_idx];
            r_dl    <= w_dl_arr[w_arb_idx];
        end else if (w_release) begin
            r_grant <= '0;
        end else begin
            r_grant <= r_grant;
        end
    end

    // Pointer moves past the finished owner so a held request cannot starve others
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_release) begin
            if (r_idx == IDX_W'(NUM_REQ-1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_idx + IDX_W'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign grant_o          = r_grant;
    assign grant_idx_o      = r_idx;
    assign busy_o           = (r_state != IDLE);
    assign done_o           = (r_state == TAG) ? r_grant : '0;
    assign core_start_o     = (r_state == LAUNCH) || (r_state == BUSY) || (r_state == TAG);
    assign core_ad_blk_no_o = r_ad;
    assign core_pt_blk_no_o = r_pt;
    assign core_delay_o     = r_dl;

`ifdef ASCON_SCHED_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] r_job_cnt [NUM_REQ];
    logic [BUSY_CNT_WIDTH-1:0] r_busy_cycles;

    // Saturating usage counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cycles <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_job_cnt[i] <= '0;
            end
        end else begin
            if (r_state != IDLE) begin
                r_busy_cycles <= sat_inc_busy(r_busy_cycles);
            end else begin
                r_busy_cycles <= r_busy_cycles;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((r_state == TAG) && r_grant[i]) begin
                    r_job_cnt[i] <= sat_inc_stat(r_job_cnt[i]);
                end else begin
                    r_job_cnt[i] <= r_job_cnt[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_out
        assign job_cnt_o[g*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = r_job_cnt[g];
    end
    assign busy_cycles_o = r_busy_cycles;
`endif

endmodule

// File: tb/tb_ascon_job_sched.sv
// Directed bench for ascon_job_sched: stimulus pushes expected completions into a
// queue; a negedge monitor pops and checks them whenever done_o pulses.
module tb_ascon_job_sched;

    localparam int NUM_REQ     = 2;
    localparam int BLOCK_AW    = 7;
    localparam int DELAY_WIDTH = 16;

    logic                            clk;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              req_i;
    logic [NUM_REQ*BLOCK_AW-1:0]     ad_blk_no_i;
    logic [NUM_REQ*(BLOCK_AW+1)-1:0] pt_blk_no_i;
    logic [NUM_REQ*DELAY_WIDTH-1:0]  delay_i;
    logic [NUM_REQ-1:0]              grant_o;
    logic                            grant_idx_o;
    logic                            busy_o;
    logic [NUM_REQ-1:0]              done_o;
    logic                            core_start_o;
    logic                            core_ready_i;
    logic                            core_tag_valid_i;
    logic [BLOCK_AW-1:0]             core_ad_blk_no_o;
    logic [BLOCK_AW:0]               core_pt_blk_no_o;
    logic [DELAY_WIDTH-1:0]          core_delay_o;
`ifdef ASCON_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0]           job_cnt_o;
    logic [31:0]                     busy_cycles_o;
`endif

    typedef struct {
        logic [NUM_REQ-1:0]     oh;
        logic [BLOCK_AW-1:0]    ad;
        logic [BLOCK_AW:0]      pt;
        logic [DELAY_WIDTH-1:0] dl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_busy = 0;

    ascon_job_sched #(
        .NUM_REQ     (NUM_REQ),
        .BLOCK_AW    (BLOCK_AW),
        .DELAY_WIDTH (DELAY_WIDTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req_i),
        .ad_blk_no_i      (ad_blk_no_i),
        .pt_blk_no_i      (pt_blk_no_i),
        .delay_i          (delay_i),
        .grant_o          (grant_o),
        .grant_idx_o      (grant_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .core_start_o     (core_start_o),
        .core_ready_i     (core_ready_i),
        .core_tag_valid_i (core_tag_valid_i),
        .core_ad_blk_no_o (core_ad_blk_no_o),
        .core_pt_blk_no_o (core_pt_blk_no_o),
        .core_delay_o     (core_delay_o)
`ifdef ASCON_SCHED_STATS_EN
        ,
        .job_cnt_o        (job_cnt_o),
        .busy_cycles_o    (busy_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int r, input int ad, input int pt, input int dl);
        ad_blk_no_i[r*BLOCK_AW +: BLOCK_AW]           = BLOCK_AW'(ad);
        pt_blk_no_i[r*(BLOCK_AW+1) +: (BLOCK_AW+1)]   = (BLOCK_AW+1)'(pt);
        delay_i[r*DELAY_WIDTH +: DELAY_WIDTH]         = DELAY_WIDTH'(dl);
    endtask

    // Completion monitor: every done_o pulse must match the oldest expected job
    always @(negedge clk) begin
        if (rst_n && done_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_onehot", 32'(done_o), 32'(e.oh));
                chk("done_ad", 32'(core_ad_blk_no_o), 32'(e.ad));
                chk("done_pt", 32'(core_pt_blk_no_o), 32'(e.pt));
                chk("done_dl", 32'(core_delay_o), 32'(e.dl));
            end
        end
    end

    // Plays the core side of one job; mode 1 perturbs winner config and drops req,
    // mode 2 raises req on both requesters while busy.
    task automatic do_job(input int idx, input int ad, input int pt, input int dl,
                          input int max_wait, input int mode);
        exp_t e;
        int   n;
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        e.oh = oh; e.ad = BLOCK_AW'(ad); e.pt = (BLOCK_AW+1)'(pt); e.dl = DELAY_WIDTH'(dl);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_start_o && n < max_wait);
        chk("start_seen", 32'(core_start_o), 32'd1);
        if (!core_start_o) return;
        exp_q.push_back(e);
        exp_busy++;
        chk("grant_oh", 32'(grant_o), 32'(oh));
        chk("grant_idx", 32'(grant_idx_o), 32'(idx));
        chk("busy_launch", 32'(busy_o), 32'd1);
        chk("cfg_ad", 32'(core_ad_blk_no_o), 32'(e.ad));
        chk("cfg_pt", 32'(core_pt_blk_no_o), 32'(e.pt));
        chk("cfg_dl", 32'(core_delay_o), 32'(e.dl));
        core_ready_i = 1'b0;
        @(negedge clk);
        exp_busy++;
        chk("start_busy", 32'(core_start_o), 32'd1);
        chk("done_quiet", 32'(done_o), 32'd0);
        if (mode == 1) begin
            ad_blk_no_i[idx*BLOCK_AW +: BLOCK_AW] = 7'd77;
            req_i = '0;
        end else if (mode == 2) begin
            req_i = '1;
        end
        repeat (2) begin
            @(negedge clk);
            exp_busy++;
            chk("cfg_hold", 32'(core_ad_blk_no_o), 32'(e.ad));
            chk("grant_hold", 32'(grant_o), 32'(oh));
        end
        core_tag_valid_i = 1'b1;
        @(negedge clk);
        exp_busy++;
        chk("start_tag", 32'(core_start_o), 32'd1);
        @(negedge clk);
        exp_busy++;
        chk("start_release", 32'(core_start_o), 32'd0);
        chk("grant_release", 32'(grant_o), 32'(oh));
        chk("done_release", 32'(done_o), 32'd0);
        core_tag_valid_i = 1'b0;
        core_ready_i     = 1'b1;
        @(negedge clk);
        chk("grant_cleared", 32'(grant_o), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_grant"}, 32'(grant_o), 32'd0);
        chk({nm, "_idx"}, 32'(grant_idx_o), 32'd0);
        chk({nm, "_busy"}, 32'(busy_o), 32'd0);
        chk({nm, "_done"}, 32'(done_o), 32'd0);
        chk({nm, "_start"}, 32'(core_start_o), 32'd0);
        chk({nm, "_ad"}, 32'(core_ad_blk_no_o), 32'd0);
        chk({nm, "_pt"}, 32'(core_pt_blk_no_o), 32'd0);
        chk({nm, "_dl"}, 32'(core_delay_o), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_i = '0; ad_blk_no_i = '0; pt_blk_no_i = '0; delay_i = '0;
        core_ready_i = 1'b1; core_tag_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single job with one-cycle grant latency
        set_cfg(0, 2, 3, 0);
        req_i = 2'b01;
        do_job(0, 2, 3, 0, 1, 0);
        req_i = '0;

        // Contention from reset: strict alternation 0,1,0,1
        pulse_reset();
        set_cfg(0, 5, 6, 7);
        set_cfg(1, 9, 10, 100);
        req_i = 2'b11;
        do_job(0, 5, 6, 7, 1, 0);
        do_job(1, 9, 10, 100, 1, 0);
        do_job(0, 5, 6, 7, 1, 0);
        do_job(1, 9, 10, 100, 1, 0);
        req_i = '0;

        // Requester 1 holds req through done while 0 is pending
        req_i = 2'b10;
        do_job(1, 9, 10, 100, 20, 2);
        do_job(0, 5, 6, 7, 1, 0);
        req_i = '0;

        // Config change and req drop mid-job are ignored
        req_i = 2'b01;
        do_job(0, 5, 6, 7, 20, 1);
        set_cfg(0, 5, 6, 7);

        // Core not ready: no grant until ready returns
        core_ready_i = 1'b0;
        req_i = 2'b01;
        repeat (4) begin
            @(negedge clk);
            chk("notready_grant", 32'(grant_o), 32'd0);
            chk("notready_busy", 32'(busy_o), 32'd0);
        end
        core_ready_i = 1'b1;
        do_job(0, 5, 6, 7, 1, 0);
        req_i = '0;

        // Tag valid while idle is ignored
        core_tag_valid_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_tag_busy", 32'(busy_o), 32'd0);
            chk("idle_tag_done", 32'(done_o), 32'd0);
        end
        core_tag_valid_i = 1'b0;

        // Asynchronous reset while the core is busy
        req_i = 2'b10;
        @(negedge clk);
        chk("pre_rst_start", 32'(core_start_o), 32'd1);
        core_ready_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midjob_rst");
        @(negedge clk);
        req_i = '0; core_ready_i = 1'b1; rst_n = 1'b1;
        exp_busy = 0;
        @(negedge clk);
        check_all_zero("after_rst");

`ifdef ASCON_SCHED_STATS_EN
        req_i = 2'b10;
        repeat (3) do_job(1, 9, 10, 100, 20, 0);
        req_i = '0;
        chk("job_cnt1", 32'(job_cnt_o[31:16]), 32'd3);
        chk("job_cnt0", 32'(job_cnt_o[15:0]), 32'd0);
        chk("busy_cycles", busy_cycles_o, 32'(exp_busy));
`endif

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
